// File: rtl/dht_pkg.sv
// Shared DHT11 definitions: frame geometry, responder state type and the
// checksum rule used by both the responder and the frame checker.
package dht_pkg;

   localparam int FRAME_BITS = 40;
   localparam int DATA_BITS  = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOST_LOW,
      S_RESP_WAIT,
      S_RESP_LOW,
      S_RESP_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_END_LOW
   } dht_state_e;

   // Mod-256 sum of the four data bytes; carries fall off the 8-bit result.
   function automatic logic [7:0] dht_checksum(input logic [31:0] d);
      logic [7:0] s;
      s = d[7:0] + d[15:8] + d[23:16] + d[31:24];
      return s;
   endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// Signal bundle between the DHT11 responder and whoever feeds it data and
// watches the bus. There is no valid/ready pair here: data_in/inject_err are
// sampled only on the cycle a start request is accepted, busy spans the whole
// answer, and frame_done is a single-cycle strobe as the line is released.
interface dht11_responder_if;
   import dht_pkg::*;

   logic [31:0] data_in;
   logic        inject_err;
   logic        dht_in;
   logic        dht_drive_low;
   logic        busy;
   logic        frame_done;
   logic [39:0] frame_sent;
   dht_state_e  state;        // responder FSM state, exported for observation

   modport master (
      output data_in, inject_err, dht_in,
      input  dht_drive_low, busy, frame_done, frame_sent, state
   );

   modport slave (
      input  data_in, inject_err, dht_in,
      output dht_drive_low, busy, frame_done, frame_sent, state
   );

endinterface

// File: rtl/dht_us_timer.sv
// Microsecond phase timer: a prescaler producing one tick per microsecond and
// a saturating microsecond counter. clear restarts both, so a phase of len
// microseconds signals done on its final clock cycle.
module dht_us_timer #(
   parameter int CLKS_PER_US = 50,
   parameter int CW          = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic [CW-1:0] len,
   output logic [CW-1:0] us_cnt,
   output logic          done
);

   localparam int            PW      = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_US - 1);

   logic [PW-1:0] pre_q;
   logic          tick;

   assign tick = (pre_q == PRE_MAX);
   assign done = tick && (us_cnt == len - CW'(1));

   // Prescaler and microsecond count; the count holds once it reaches len.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         us_cnt <= '0;
      end else if (clear) begin
         pre_q  <= '0;
         us_cnt <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + PW'(1);
         if (tick && (us_cnt != len))
            us_cnt <= us_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a long host low pulse on the open-drain
// line, then answers with the response preamble and a 40-bit frame
// (four data bytes then checksum, each byte MSB-first).
module dht11_responder
   import dht_pkg::*;
#(
   parameter int CLKS_PER_US  = 50,
   parameter int START_MIN_US = 18000,
   parameter int RESP_WAIT_US = 30,
   parameter int RESP_LOW_US  = 80,
   parameter int RESP_HIGH_US = 80,
   parameter int BIT_LOW_US   = 50,
   parameter int ZERO_HIGH_US = 26,
   parameter int ONE_HIGH_US  = 70,
   parameter int END_LOW_US   = 50
) (
   input logic               clk,
   input logic               reset_n,
   dht11_responder_if.slave  bus
);

   localparam int          CW         = 16;
   localparam logic [CW-1:0] LEN_START = CW'(START_MIN_US);
   localparam logic [CW-1:0] LEN_WAIT  = CW'(RESP_WAIT_US);
   localparam logic [CW-1:0] LEN_RLOW  = CW'(RESP_LOW_US);
   localparam logic [CW-1:0] LEN_RHIGH = CW'(RESP_HIGH_US);
   localparam logic [CW-1:0] LEN_BLOW  = CW'(BIT_LOW_US);
   localparam logic [CW-1:0] LEN_ZERO  = CW'(ZERO_HIGH_US);
   localparam logic [CW-1:0] LEN_ONE   = CW'(ONE_HIGH_US);
   localparam logic [CW-1:0] LEN_END   = CW'(END_LOW_US);
   localparam logic [5:0]    LAST_BIT  = 6'(FRAME_BITS - 1);

   dht_state_e    state_q, state_d;
   logic [2:0]    sync_q;          // [0],[1] synchronizer, [2] previous level
   logic          fall, rise;
   logic [5:0]    bit_idx;
   logic [39:0]   frame_q;
   logic          busy_q, done_q;
   logic          latch, bit_adv, finish, clear;
   logic [CW-1:0] t_len, us_cnt;
   logic          t_done;
   logic          cur_bit;

   assign fall = sync_q[2] & ~sync_q[1];
   assign rise = ~sync_q[2] & sync_q[1];

   // Frame bit order: byte 0 first, MSB of each byte first.
   assign cur_bit = frame_q[{bit_idx[5:3], ~bit_idx[2:0]}];

   assign clear = (state_d != state_q);

   dht_us_timer #(.CLKS_PER_US(CLKS_PER_US), .CW(CW)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .len     (t_len),
      .us_cnt  (us_cnt),
      .done    (t_done)
   );

   // Bring the asynchronous bus level into the clock domain; idle level is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 3'b111;
      else          sync_q <= {sync_q[1:0], bus.dht_in};
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state, phase length and single-cycle control strobes.
   always_comb begin
      state_d = state_q;
      t_len   = LEN_START;
      latch   = 1'b0;
      bit_adv = 1'b0;
      finish  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fall) state_d = S_HOST_LOW;
         end
         S_HOST_LOW: begin
            t_len = LEN_START;
            if (rise) begin
               if (us_cnt >= LEN_START) begin
                  latch   = 1'b1;
                  state_d = S_RESP_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RESP_WAIT: begin
            t_len = LEN_WAIT;
            if (t_done) state_d = S_RESP_LOW;
         end
         S_RESP_LOW: begin
            t_len = LEN_RLOW;
            if (t_done) state_d = S_RESP_HIGH;
         end
         S_RESP_HIGH: begin
            t_len = LEN_RHIGH;
            if (t_done) state_d = S_BIT_LOW;
         end
         S_BIT_LOW: begin
            t_len = LEN_BLOW;
            if (t_done) state_d = S_BIT_HIGH;
         end
         S_BIT_HIGH: begin
            t_len = cur_bit ? LEN_ONE : LEN_ZERO;
            if (t_done) begin
               if (bit_idx == LAST_BIT) begin
                  state_d = S_END_LOW;
               end else begin
                  bit_adv = 1'b1;
                  state_d = S_BIT_LOW;
               end
            end
         end
         S_END_LOW: begin
            t_len = LEN_END;
            if (t_done) begin
               finish  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame latch, bit index, busy span and completion strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_q <= '0;
         bit_idx <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= finish;
         if (latch) begin
            frame_q <= {dht_checksum(bus.data_in) ^ {8{bus.inject_err}}, bus.data_in};
            bit_idx <= '0;
            busy_q  <= 1'b1;
         end else if (bit_adv) begin
            bit_idx <= bit_idx + 6'd1;
         end
         if (finish) busy_q <= 1'b0;
      end
   end

   // The line is pulled low only in the driven phases; reset releases it at once.
   assign bus.dht_drive_low = (state_q == S_RESP_LOW) || (state_q == S_BIT_LOW) ||
                              (state_q == S_END_LOW);
   assign bus.busy          = busy_q;
   assign bus.frame_done    = done_q;
   assign bus.frame_sent    = frame_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for the DHT11 responder: an open-drain bus with a host that can pull
// it low, a per-cycle expected trace of busy/drive/done/frame built from the
// protocol timing, a bus-level bit decoder, and literal frame expectations.
module tb_dht11_responder;
   import dht_pkg::*;

   localparam int C      = 2;
   localparam int SMIN   = 20;
   localparam int WAIT   = 30;
   localparam int RLOW   = 80;
   localparam int RHIGH  = 80;
   localparam int BLOW   = 50;
   localparam int ZHIGH  = 26;
   localparam int OHIGH  = 70;
   localparam int ELOW   = 50;

   logic clk;
   logic reset_n;
   logic host_low;
   logic dht_line;

   int checks   = 0;
   int failures = 0;

   logic [42:0] exp_q[$];      // {busy, drive_low, frame_done, frame_sent}
   logic [39:0] last_frame;

   logic [39:0] rx;
   int          hi_len;
   int          nruns;
   logic        busy_prev;

   dht11_responder_if bus ();

   dht11_responder #(
      .CLKS_PER_US (C),
      .START_MIN_US(SMIN),
      .RESP_WAIT_US(WAIT),
      .RESP_LOW_US (RLOW),
      .RESP_HIGH_US(RHIGH),
      .BIT_LOW_US  (BLOW),
      .ZERO_HIGH_US(ZHIGH),
      .ONE_HIGH_US (OHIGH),
      .END_LOW_US  (ELOW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // Open-drain bus with pull-up: low if either side pulls it.
   assign dht_line   = ~(bus.dht_drive_low | host_low);
   assign bus.dht_in = dht_line;

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- model ----------------
   function automatic logic [39:0] model_frame(input logic [31:0] d, input logic e);
      int         s;
      logic [7:0] c;
      s = 0;
      for (int b = 0; b < 4; b++) s = s + int'(d[b*8 +: 8]);
      c = 8'(s % 256);
      if (e) c = ~c;
      return {c, d};
   endfunction

   function automatic int high_us(input logic [39:0] f, input int k);
      logic [7:0] byt;
      byt = f[(k / 8) * 8 +: 8];
      return byt[7 - (k % 8)] ? OHIGH : ZHIGH;
   endfunction

   task automatic push_n(input int n, input logic bsy, input logic drv,
                         input logic dn, input logic [39:0] f);
      repeat (n) exp_q.push_back({bsy, drv, dn, f});
   endtask

   task automatic build_trace(input logic [39:0] f);
      push_n(WAIT * C, 1'b1, 1'b0, 1'b0, f);
      push_n(RLOW * C, 1'b1, 1'b1, 1'b0, f);
      push_n(RHIGH * C, 1'b1, 1'b0, 1'b0, f);
      for (int k = 0; k < 40; k++) begin
         push_n(BLOW * C, 1'b1, 1'b1, 1'b0, f);
         push_n(high_us(f, k) * C, 1'b1, 1'b0, 1'b0, f);
      end
      push_n(ELOW * C, 1'b1, 1'b1, 1'b0, f);
      push_n(1, 1'b0, 1'b0, 1'b1, f);
   endtask

   // ---------------- checks ----------------
   task automatic check40(input string name, input logic [39:0] act, input logic [39:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Per-cycle comparison of the DUT outputs against the expected trace.
   always @(negedge clk) begin
      logic [42:0] e;
      logic [42:0] a;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {3'b000, last_frame};
      a = {bus.busy, bus.dht_drive_low, bus.frame_done, bus.frame_sent};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL cycle t=%0t: got busy=%b drv=%b done=%b frame=%h expected busy=%b drv=%b done=%b frame=%h",
                  $time, a[42], a[41], a[40], a[39:0], e[42], e[41], e[40], e[39:0]);
      end
   end

   // Bus-level decoder: bit value from the length of each released phase.
   always @(negedge clk) begin
      if (bus.busy && !busy_prev) begin
         nruns = 0;
         rx    = '0;
      end
      if (dht_line) begin
         hi_len++;
      end else begin
         if (hi_len > 0 && bus.busy) begin
            nruns++;
            if (nruns > 2) rx = {rx[38:0], (hi_len > 96)};
         end
         hi_len = 0;
      end
      busy_prev = bus.busy;
   end

   // ---------------- drivers ----------------
   task automatic host_pulse(input int us);
      @(posedge clk); #2;
      host_low = 1'b1;
      repeat (us * C) @(posedge clk);
      #2;
      host_low = 1'b0;
   endtask

   task automatic start_frame(input logic [31:0] d, input logic e, input int us);
      logic [39:0] f;
      bus.data_in    = d;
      bus.inject_err = e;
      host_pulse(us);
      // Two synchronizer stages plus the edge detector before acceptance.
      push_n(3, 1'b0, 1'b0, 1'b0, last_frame);
      f = model_frame(d, e);
      build_trace(f);
      last_frame = f;
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      repeat (5) @(posedge clk);
      #2;
      bus.data_in    = $urandom;
      bus.inject_err = 1'($urandom_range(0, 1));
      while (exp_q.size() != 0 && n < 25000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL frame_timeout: %0d expected cycles left, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   function automatic logic rx_cks_err(input logic [39:0] r);
      logic [7:0] s;
      s = r[39:32] + r[31:24] + r[23:16] + r[15:8];
      return s != r[7:0];
   endfunction

   task automatic check_frame(input string name, input logic [39:0] frame_lit,
                              input logic [39:0] rx_lit, input logic err_lit);
      check40({name, "_frame_sent"}, bus.frame_sent, frame_lit);
      check40({name, "_serial"}, rx, rx_lit);
      check40({name, "_cks_flag"}, {39'd0, rx_cks_err(rx)}, {39'd0, err_lit});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      logic [39:0] f6;
      reset_n        = 1'b0;
      host_low       = 1'b0;
      bus.data_in    = '0;
      bus.inject_err = 1'b0;
      last_frame     = '0;
      rx             = '0;
      hi_len         = 0;
      nruns          = 0;
      busy_prev      = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b1;
      check40("reset_frame_sent", bus.frame_sent, 40'h0);
      check40("reset_outputs", {37'd0, bus.busy, bus.dht_drive_low, bus.frame_done}, 40'h0);
      check40("reset_state", {37'd0, bus.state}, {37'd0, S_IDLE});

      // Nominal frame
      start_frame(32'h0019003C, 1'b0, 25);
      wait_frame();
      check_frame("nominal", 40'h550019003C, 40'h3C00190055, 1'b0);

      // Checksum wraps past 8 bits
      start_frame(32'h0201FFFF, 1'b0, 25);
      wait_frame();
      check_frame("wrap", 40'h010201FFFF, 40'hFFFF010201, 1'b0);

      // Short start pulse is ignored, a proper one then works
      host_pulse(10);
      repeat (30) @(posedge clk);
      #2;
      check40("short_state", {37'd0, bus.state}, {37'd0, S_IDLE});
      check40("short_busy", {39'd0, bus.busy}, 40'h0);
      start_frame(32'h12345678, 1'b0, 25);
      wait_frame();
      check_frame("after_short", 40'h1412345678, 40'h7856341214, 1'b0);

      // Corrupted checksum
      start_frame(32'h0019003C, 1'b1, 25);
      wait_frame();
      check_frame("inject", 40'hAA0019003C, 40'h3C001900AA, 1'b1);

      // Reset 20 cycles into the driven low phase of bit 17
      start_frame(32'h0019003C, 1'b0, 25);
      f6 = model_frame(32'h0019003C, 1'b0);
      t = 3 + (WAIT + RLOW + RHIGH) * C + 20;
      for (int k = 0; k < 17; k++) t = t + (BLOW + high_us(f6, k)) * C;
      repeat (t) @(posedge clk);
      #2;
      check40("pre_reset_drive", {39'd0, bus.dht_drive_low}, 40'h1);
      exp_q.delete();
      last_frame = '0;
      reset_n    = 1'b0;
      #1;
      check40("async_reset_drive", {39'd0, bus.dht_drive_low}, 40'h0);
      check40("async_reset_outputs", {bus.busy, bus.frame_done, bus.frame_sent[37:0]}, 40'h0);
      check40("async_reset_frame", bus.frame_sent, 40'h0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      start_frame(32'hA5A55A5A, 1'b0, 25);
      wait_frame();
      check_frame("post_reset", 40'hFEA5A55A5A, 40'h5A5AA5A5FE, 1'b0);

      repeat (10) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
